// File: rtl/rng_service_arbiter.sv
// Shared pseudo-random source for DynaQ consumers: owns the generator state and hands out
// one fresh value per grant via round-robin req/gnt arbitration, with seeding and warm-up.
`timescale 1ns/1ps
module rng_service_arbiter #(
  parameter int unsigned              DATA_LENGTH   = 32,
  parameter int unsigned              NUM_REQ       = 4,
  parameter int unsigned              WARMUP_CYCLES = 8,
  parameter logic [DATA_LENGTH-1:0]   DEFAULT_SEED  = 32'h0000_0001
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_seed_load,
  input  logic [DATA_LENGTH-1:0] i_seed,
  input  logic [NUM_REQ-1:0]     i_req,
  output logic [NUM_REQ-1:0]     o_gnt,
  output logic [DATA_LENGTH-1:0] o_rnd_data,
  output logic                   o_busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]  WarmInit = 8'(WARMUP_CYCLES);

  typedef enum logic {StWarmup, StServe} state_e;
  localparam state_e StInit = (WARMUP_CYCLES == 0) ? StServe : StWarmup;

  function automatic logic [DATA_LENGTH-1:0] f_next(input logic [DATA_LENGTH-1:0] s);
    return {s[DATA_LENGTH-2:0], ~^s[DATA_LENGTH-1:DATA_LENGTH/2]};
  endfunction

  state_e                 r_fsm,  w_fsm_nxt;
  logic [7:0]             r_cnt,  w_cnt_nxt;
  logic [DATA_LENGTH-1:0] r_lfsr, w_lfsr_nxt;
  logic [IdxW-1:0]        r_ptr,  w_ptr_nxt;
  logic [NUM_REQ-1:0]     r_last, w_last_nxt;
  logic [NUM_REQ-1:0]     r_gnt,  w_gnt_nxt;
  logic [DATA_LENGTH-1:0] r_rnd,  w_rnd_nxt;

  logic [NUM_REQ-1:0]     w_elig;
  logic                   w_hit;
  logic [IdxW-1:0]        w_sel;
  int unsigned            w_j;

  assign w_elig = i_req & ~r_last;

  // First eligible requester at or after the pointer, wrapping.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_j   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = (32'(r_ptr) + 32'(k)) % NUM_REQ;
      if (!w_hit && w_elig[w_j[IdxW-1:0]]) begin
        w_hit = 1'b1;
        w_sel = w_j[IdxW-1:0];
      end
    end
  end

  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_cnt_nxt  = r_cnt;
    w_lfsr_nxt = r_lfsr;
    w_ptr_nxt  = r_ptr;
    w_last_nxt = r_last;
    w_gnt_nxt  = '0;
    w_rnd_nxt  = r_rnd;
    if (i_seed_load) begin
      // All-ones is a fixed point of the generator, so it is never loaded.
      w_lfsr_nxt = (i_seed == '1) ? DEFAULT_SEED : i_seed;
      w_cnt_nxt  = WarmInit;
      w_fsm_nxt  = StInit;
      w_ptr_nxt  = '0;
      w_last_nxt = '0;
    end else begin
      unique case (r_fsm)
        StWarmup: begin
          w_lfsr_nxt = f_next(r_lfsr);
          w_cnt_nxt  = r_cnt - 8'd1;
          if (r_cnt <= 8'd1) w_fsm_nxt = StServe;
        end
        StServe: begin
          if (w_hit) begin
            w_gnt_nxt  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
            w_rnd_nxt  = r_lfsr;
            w_lfsr_nxt = f_next(r_lfsr);
            w_ptr_nxt  = (w_sel == IdxW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
            w_last_nxt = w_gnt_nxt;
          end else begin
            w_last_nxt = '0;
          end
        end
        default: w_fsm_nxt = StInit;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm  <= StInit;
      r_cnt  <= WarmInit;
      r_lfsr <= DEFAULT_SEED;
      r_ptr  <= '0;
      r_last <= '0;
      r_gnt  <= '0;
      r_rnd  <= '0;
    end else begin
      r_fsm  <= w_fsm_nxt;
      r_cnt  <= w_cnt_nxt;
      r_lfsr <= w_lfsr_nxt;
      r_ptr  <= w_ptr_nxt;
      r_last <= w_last_nxt;
      r_gnt  <= w_gnt_nxt;
      r_rnd  <= w_rnd_nxt;
    end
  end

  assign o_gnt      = r_gnt;
  assign o_rnd_data = r_rnd;
  assign o_busy     = (r_fsm == StWarmup);

endmodule

// File: tb/tb_rng_service_arbiter.sv
// Bench for rng_service_arbiter: two instances (default warm-up and no warm-up), a per-cycle
// reference model feeding grant scoreboards, and a negedge monitor that checks every grant.
`timescale 1ns/1ps
module tb_rng_service_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sl0;
  logic [31:0] seed0;
  logic [3:0]  req0, req1;
  logic [3:0]  gnt0, gnt1;
  logic [31:0] rnd0, rnd1;
  logic        busy0, busy1;

  always #5 clk = ~clk;

  rng_service_arbiter u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_seed_load(sl0), .i_seed(seed0), .i_req(req0),
    .o_gnt(gnt0), .o_rnd_data(rnd0), .o_busy(busy0)
  );

  rng_service_arbiter #(.WARMUP_CYCLES(0)) u_dut_nw (
    .i_clk(clk), .i_rst_n(rst_n), .i_seed_load(1'b0), .i_seed(32'h0), .i_req(req1),
    .o_gnt(gnt1), .o_rnd_data(rnd1), .o_busy(busy1)
  );

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ngrant[2];
  logic [31:0] last_val[2];

  // Reference model: abstract state per instance.
  logic [31:0] m_state[2];
  int          m_warm[2];
  int          m_ptr[2];
  int          m_last[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] nxt(input logic [31:0] s);
    logic fb;
    fb = ($countones(s[31:16]) % 2 == 0);
    return {s[30:0], fb};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 32'h1;
      m_warm[d]  = (d == 0) ? 8 : 0;
      m_ptr[d]   = 0;
      m_last[d]  = -1;
    end
  endtask

  task automatic model_eval(input int d, input logic [3:0] req, input logic sl,
                            input logic [31:0] sd);
    exp_t e;
    if (sl) begin
      m_state[d] = (sd == 32'hFFFF_FFFF) ? 32'h1 : sd;
      m_warm[d]  = (d == 0) ? 8 : 0;
      m_ptr[d]   = 0;
      m_last[d]  = -1;
      return;
    end
    if (m_warm[d] > 0) begin
      m_state[d] = nxt(m_state[d]);
      m_warm[d]--;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr[d] + k) % 4;
      if (req[i] && i != m_last[d]) begin
        e.due = cyc + 1;
        e.idx = i;
        e.val = m_state[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        m_state[d] = nxt(m_state[d]);
        m_ptr[d]   = (i + 1) % 4;
        m_last[d]  = i;
        return;
      end
    end
    m_last[d] = -1;
  endtask

  task automatic mon(input int d, input logic [3:0] g, input logic [31:0] r);
    exp_t e;
    int   n;
    n = (d == 0) ? q0.size() : q1.size();
    if (g != 4'b0) begin
      chk("gnt_onehot", 32'($countones(g)), 32'd1);
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_gnt[%0d]: got %b expected none (cycle %0d)", d, g, cyc);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk("gnt_idx", 32'(g), 32'(4'b0001 << e.idx));
        chk("rnd_data", r, e.val);
      end
      ngrant[d]++;
      last_val[d] = r;
    end else if (n > 0) begin
      e = (d == 0) ? q0[0] : q1[0];
      if (e.due <= cyc) begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_gnt[%0d]: got 0 expected idx %0d (cycle %0d)", d, e.idx, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, gnt0, rnd0);
      mon(1, gnt1, rnd1);
    end
  end

  // One clock: check busy, advance model, cross the edge, return after the monitor ran.
  task automatic step();
    chk("busy0", 32'(busy0), 32'(m_warm[0] > 0));
    chk("busy1", 32'(busy1), 32'(m_warm[1] > 0));
    model_eval(0, req0, sl0, seed0);
    model_eval(1, req1, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    sl0 = 1'b0;
  endtask

  task automatic wait_grant(input int d, input int target, input int budget);
    int n;
    n = 0;
    while (ngrant[d] < target && n < budget) begin
      step();
      n++;
    end
    chk("grant_timeout", 32'(ngrant[d] >= target), 32'd1);
  endtask

  initial begin
    int base;
    int found;
    ngrant[0] = 0;
    ngrant[1] = 0;
    rst_n = 1'b0;
    sl0   = 1'b0;
    seed0 = 32'h0;
    req0  = 4'b0;
    req1  = 4'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt0), 32'h0);
    chk("rst_rnd", rnd0, 32'h0);
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_busy_nw", 32'(busy1), 32'd0);
    rst_n = 1'b1;

    // Warm-up, then two grants to requester 0.
    repeat (10) step();
    req0 = 4'b0001;
    base = ngrant[0];
    wait_grant(0, base + 1, 6);
    chk("first_val", last_val[0], 32'h0000_01FF);
    wait_grant(0, base + 2, 6);
    chk("second_val", last_val[0], 32'h0000_03FF);
    req0 = 4'b0;
    step();

    // All requesters held.
    req0 = 4'b1111;
    base = ngrant[0];
    wait_grant(0, base + 8, 20);
    req0 = 4'b0;
    step();

    // No-warm-up instance, single requester held.
    req1 = 4'b0100;
    base = ngrant[1];
    wait_grant(1, base + 4, 12);
    chk("nw_fourth_val", last_val[1], 32'h0000_000F);
    req1 = 4'b0;
    step();

    // Illegal seed falls back to the default.
    sl0   = 1'b1;
    seed0 = 32'hFFFF_FFFF;
    step();
    req0 = 4'b0001;
    base = ngrant[0];
    wait_grant(0, base + 1, 15);
    chk("illegal_seed_val", last_val[0], 32'h0000_01FF);

    // Seed load collides with a pending grant.
    req0 = 4'b1111;
    step();
    step();
    sl0   = 1'b1;
    seed0 = 32'h0;
    step();
    chk("seed_drop_gnt", 32'(gnt0), 32'h0);
    base = ngrant[0];
    wait_grant(0, base + 1, 15);
    chk("zero_seed_val", last_val[0], 32'h0000_00FF);

    // Reset while gnt[1] is high.
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step();
      if (gnt0 == 4'b0010) found = 1;
    end
    chk("saw_gnt1", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt0), 32'h0);
    chk("async_rst_rnd", rnd0, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    base = ngrant[0];
    wait_grant(0, base + 1, 15);
    chk("post_rst_val", last_val[0], 32'h0000_01FF);

    // Randomised traffic with occasional reseeding.
    for (int i = 0; i < 400; i++) begin
      req0 = 4'($urandom);
      req1 = 4'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        sl0   = 1'b1;
        seed0 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      step();
    end
    req0 = 4'b0;
    req1 = 4'b0;
    repeat (3) step();
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rng_service_arbiter.md
Name: rng_service_arbiter

Overview:
- Owns the DynaQ pseudo-random state register and steps it with the team's `random_generator` next-state function.
- Shares the random stream among NUM_REQ requesters, such as epsilon-greedy action select and planning-step state/action sampling.
- Arbitration is round-robin with a req/gnt handshake.
- Handles seeding, seed sanitising and a post-seed warm-up so that every consumer sees a deterministic, non-repeating value per grant.

Parameters:
- DATA_LENGTH, 32: width of the random state and the output value (even, >= 4).
- NUM_REQ, 4: number of requesters (2..8).
- WARMUP_CYCLES, 8: generator steps discarded after reset or seed load (0..255).
- DEFAULT_SEED, 32'h0000_0001: state used after reset and in place of an illegal seed.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- seed_load, input, 1: single-cycle pulse that loads seed.
- seed, input, DATA_LENGTH: new seed value.
- req, input, NUM_REQ: per-requester request, level.
- gnt, output, NUM_REQ: one-hot, single-cycle grant (registered).
- rnd_data, output, DATA_LENGTH: random value, valid in the cycle gnt is nonzero (registered).
- busy, output, 1: high during warm-up; no grants are issued while high.

Behaviour:
- Next-state function: `next(s) = {s[DATA_LENGTH-2:0], ~^s[DATA_LENGTH-1:DATA_LENGTH/2]}`. The state is stepped only through this function.
- Illegal seed: all-ones is a fixed point of the function. A seed equal to all-ones is replaced by DEFAULT_SEED. All-zero is legal, since the feedback bit is 1.
- Reset (async assert, sync release):
  - state = DEFAULT_SEED, gnt = 0, rnd_data = 0.
  - Round-robin pointer = 0, last-grant mask = 0.
  - FSM = WARMUP with counter = WARMUP_CYCLES, busy = 1. If WARMUP_CYCLES = 0, the FSM enters SERVE instead and busy = 0.
- FSM states:
  - WARMUP:
    - Each cycle: state <= next(state), counter decrements, gnt = 0, busy = 1.
    - In the cycle the counter reaches 0, go to SERVE; busy = 0 from the following cycle.
  - SERVE:
    - Eligible set = req & ~last_gnt. A requester granted in the previous cycle is excluded for one cycle, so holding req high yields at most one grant per two cycles.
    - If the eligible set is nonzero, select the first eligible index at or after the pointer, wrapping modulo NUM_REQ. Then, on the next edge:
      - gnt <= onehot(i), rnd_data <= state, state <= next(state);
      - pointer <= (i+1) mod NUM_REQ, last_gnt <= onehot(i).
    - If the eligible set is zero: gnt <= 0, state and pointer hold, last_gnt <= 0, rnd_data holds its last value.
- Latency: a req first eligible in cycle t is granted in cycle t+1 at the earliest. Throughput is one grant per cycle across requesters.
- seed_load has priority over everything, in any state:
  - On the next edge: state <= sanitised seed, gnt <= 0 (a grant due that edge is dropped), counter <= WARMUP_CYCLES, FSM <= WARMUP (or SERVE if WARMUP_CYCLES = 0).
  - Pointer and last_gnt are cleared.
  - A seed_load during warm-up restarts warm-up.
- Simultaneous requests: exactly one grant per cycle. gnt is never multi-hot.
- A requester must deassert req in the cycle it observes gnt, or it is treated as a new request after the one-cycle exclusion.
- Reset asserted mid-operation immediately clears gnt and forces the reset values.
- State advances only on warm-up steps and on grants, never on idle cycles, so the sequence is reproducible from the seed.

Test Plan:
1. Reset release with defaults, req = 0 → busy = 1 for 8 cycles, then 0. The first grant to req[0] gives rnd_data = 32'h0000_01FF, the second gives 32'h0000_03FF.
2. req = 4'b1111 held from end of warm-up → grant order 0,1,2,3,0,... with one gnt bit per cycle. Values follow the sequence 0x1FF, 0x3FF, 0x7FF, ... across requesters, with no value repeated or skipped.
3. Only req[2] held high, with WARMUP_CYCLES = 0 → gnt[2] every second cycle; state advances only on grant cycles.
4. seed_load with seed = 32'hFFFF_FFFF → state is reloaded from DEFAULT_SEED, and the first post-warm-up value equals 32'h0000_01FF.
5. seed_load with seed = 32'h0000_0000 in the same cycle a grant would issue → no gnt and busy = 1 for 8 cycles. The first value is then 32'h0000_00FF, since 0 steps 1,3,7,...,0xFF.
6. rst_n asserted while gnt[1] is high mid-sequence → gnt = 0 and rnd_data = 0 immediately. After release, the stream restarts at 0x1FF.
